// File: rtl/convolver.sv
// Streaming K x K, stride-S 2-D correlation over an N x N raster-order pixel stream.
// Define CONVOLVER_WEIGHT_PORT_EN to take the kernel from the weight1 port; otherwise w[i] = i.
module conv_tap (
  input  logic signed [15:0] w,
  input  logic signed [15:0] a,
  output logic signed [31:0] p
);
  assign p = w * a;
endmodule

module convolver #(
  parameter int N = 4,
  parameter int K = 3,
  parameter int S = 1
) (
  input  logic                clk,
  input  logic                global_rst,
  input  logic                ce,
  input  logic signed [15:0]  activation,
`ifdef CONVOLVER_WEIGHT_PORT_EN
  input  logic [16*K*K-1:0]   weight1,
`endif
  output logic signed [31:0]  conv_op,
  output logic                valid_conv,
  output logic                end_conv
);
  localparam int KK    = K * K;
  localparam int DEPTH = (K - 1) * N + K;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // lbuf[DEPTH-1] is the newest pixel, so offset r*N+c is window element (r,c)
  logic [DEPTH-1:0][15:0] lbuf;
  logic [CW-1:0]          row, col;
  logic [KK-1:0][15:0]    wgt, tap;
  logic [KK-1:0][31:0]    prod;
  logic [31:0]            acc;
  logic [1:0]             vld_pipe;
  logic [1:0]             end_pipe;
  logic                   win_hit;
  int                     r_off, c_off;

  genvar i;
  generate
    for (i = 0; i < KK; i++) begin : g_tap
      localparam int R = i / K;
      localparam int C = i % K;
      assign tap[i] = lbuf[R*N+C];
`ifdef CONVOLVER_WEIGHT_PORT_EN
      assign wgt[i] = weight1[16*i +: 16];
`else
      assign wgt[i] = 16'(i);
`endif
      conv_tap u_tap (.w(wgt[i]), .a(tap[i]), .p(prod[i]));
    end
  endgenerate

  always_comb begin
    acc = '0;
    for (int j = 0; j < KK; j++) acc = acc + prod[j];
  end

  always_comb begin
    r_off   = int'(row) - (K - 1);
    c_off   = int'(col) - (K - 1);
    win_hit = (r_off >= 0) && (c_off >= 0) && (r_off % S == 0) && (c_off % S == 0);
  end

  assign valid_conv = vld_pipe[1];
  assign end_conv   = end_pipe[1];

  // Stage 0 flags the window completed by the pixel just shifted in; stage 1 registers its sum
  always_ff @(posedge clk) begin
    if (!global_rst) begin
      lbuf     <= '0;
      row      <= '0;
      col      <= '0;
      vld_pipe <= '0;
      end_pipe <= '0;
      conv_op  <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      end_pipe[1] <= end_pipe[0];
      if (vld_pipe[0]) conv_op <= acc;
      vld_pipe[0] <= 1'b0;
      end_pipe[0] <= 1'b0;
      if (ce) begin
        lbuf        <= {activation, lbuf[DEPTH-1:1]};
        vld_pipe[0] <= win_hit;
        end_pipe[0] <= win_hit && (row == LAST) && (col == LAST);
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_convolver.sv
// Bench for convolver: 2-D frame model checked every cycle, plus literal result checks.
module tb_convolver;
  localparam int K = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               global_rst, ce;
  logic signed [15:0] activation;
  logic [31:0]        op_a, op_b;
  logic               v_a, v_b, e_a, e_b;
`ifdef CONVOLVER_WEIGHT_PORT_EN
  logic [16*K*K-1:0]  weight1;
`endif

  convolver #(.N(4), .K(3), .S(1)) dut_a (
    .clk(clk), .global_rst(global_rst), .ce(ce), .activation(activation),
`ifdef CONVOLVER_WEIGHT_PORT_EN
    .weight1(weight1),
`endif
    .conv_op(op_a), .valid_conv(v_a), .end_conv(e_a));

  convolver #(.N(5), .K(3), .S(2)) dut_b (
    .clk(clk), .global_rst(global_rst), .ce(ce), .activation(activation),
`ifdef CONVOLVER_WEIGHT_PORT_EN
    .weight1(weight1),
`endif
    .conv_op(op_b), .valid_conv(v_b), .end_conv(e_b));

  int mN = 4, mS = 1, mode = 0;
  int img [5][5];
  int mrow, mcol, edge_no;
  bit pend_v, pend_end, exp_v, exp_e, checking;
  int pend_op, exp_op;
  int n_cmp = 0, n_bad = 0;
  int q_op[$], q_edge[$];
  bit q_end[$];

  function automatic int wt(int i);
`ifdef CONVOLVER_WEIGHT_PORT_EN
    return int'($signed(weight1[16*i +: 16]));
`else
    return i;
`endif
  endfunction

  // one clock edge with the given inputs; the model advances with it
  task automatic step(bit r, bit c, int a);
    int acc;
    @(negedge clk);
    global_rst = r; ce = c; activation = 16'(a);
    @(posedge clk);
    edge_no++;
    if (!r) begin
      exp_v = 0; exp_e = 0; exp_op = 0; pend_v = 0; pend_end = 0; mrow = 0; mcol = 0;
    end else begin
      exp_v = pend_v; exp_e = pend_v && pend_end;
      if (pend_v) exp_op = pend_op;
      pend_v = 0; pend_end = 0;
      if (c) begin
        img[mrow][mcol] = int'($signed(16'(a)));
        if (mrow >= K-1 && mcol >= K-1 && (mrow-K+1) % mS == 0 && (mcol-K+1) % mS == 0) begin
          acc = 0;
          for (int rr = 0; rr < K; rr++)
            for (int cc = 0; cc < K; cc++)
              acc += wt(rr*K+cc) * img[mrow-K+1+rr][mcol-K+1+cc];
          pend_v = 1; pend_op = acc; pend_end = (mrow == mN-1) && (mcol == mN-1);
        end
        if (mcol == mN-1) begin
          mcol = 0; mrow = (mrow == mN-1) ? 0 : mrow + 1;
        end else mcol++;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin : cmp
    logic [31:0] op;
    logic v, e;
    if (checking) begin
      op = mode ? op_b : op_a;
      v  = mode ? v_b : v_a;
      e  = mode ? e_b : e_a;
      n_cmp += 3;
      if (v !== exp_v) begin
        n_bad++; $display("FAIL valid_conv edge %0d: got %b want %b", edge_no, v, exp_v);
      end
      if (e !== exp_e) begin
        n_bad++; $display("FAIL end_conv edge %0d: got %b want %b", edge_no, e, exp_e);
      end
      if (op !== 32'(exp_op)) begin
        n_bad++; $display("FAIL conv_op edge %0d: got %0h want %0h", edge_no, op, 32'(exp_op));
      end
      if (v === 1'b1) begin
        q_op.push_back(int'(op)); q_end.push_back(e); q_edge.push_back(edge_no);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic clr();
    q_op.delete(); q_end.delete(); q_edge.delete(); edge_no = -1;
  endtask

  task automatic flush();
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
  endtask

  task automatic chk_frame(string nm, int o0, int o1, int o2, int o3);
    int want [4];
    want = '{o0, o1, o2, o3};
    chk({nm, "_count"}, q_op.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_op%0d", nm, i), q_op[i], want[i]);
      chk($sformatf("%s_end%0d", nm, i), 32'(q_end[i]), (i == 3) ? 1 : 0);
    end
  endtask

  task automatic chk_edges(string nm, int e0, int e1, int e2, int e3);
    int want [4];
    want = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) chk($sformatf("%s_edge%0d", nm, i), q_edge[i], want[i]);
  endtask

  initial begin
`ifdef CONVOLVER_WEIGHT_PORT_EN
    for (int i = 0; i < K*K; i++) weight1[16*i +: 16] = 16'(i);
`endif
    checking = 0; edge_no = -1;
    step(0, 1, 16'h55); step(0, 1, 16'h55);
    checking = 1;
    chk("rst_op", op_a, 0);
    chk("rst_valid", 32'(v_a), 0);
    chk("rst_end", 32'(e_a), 0);

    clr();
    for (int i = 0; i < 16; i++) step(1, 1, i);
    flush();
    chk_frame("basic", 258, 294, 402, 438);
    chk_edges("basic", 11, 12, 15, 16);

    clr();
    for (int i = 16; i < 32; i++) step(1, 1, i);
    flush();
    chk_frame("cont", 834, 870, 978, 1014);

    clr();
    for (int i = 0; i < 10; i++) step(1, 1, i);
    repeat (3) step(1, 0, 99);
    for (int i = 10; i < 16; i++) step(1, 1, i);
    flush();
    chk_frame("stall", 258, 294, 402, 438);
    chk_edges("stall", 14, 15, 18, 19);

    for (int i = 0; i < 7; i++) step(1, 1, 100 + i);
    step(0, 1, 7); step(0, 1, 7);
    chk("midrst_op", op_a, 0);
    clr();
    for (int i = 1; i <= 16; i++) step(1, 1, i);
    flush();
    chk_frame("midrst", 294, 330, 438, 474);

    clr();
    for (int i = 0; i < 16; i++) step(1, 1, -1);
    flush();
    chk_frame("neg", -36, -36, -36, -36);

`ifdef CONVOLVER_WEIGHT_PORT_EN
    for (int i = 0; i < K*K; i++) weight1[16*i +: 16] = 16'h7FFF;
    clr();
    for (int i = 0; i < 16; i++) step(1, 1, 16'h7FFF);
    flush();
    chk_frame("wrap", 32'h3FF70009, 32'h3FF70009, 32'h3FF70009, 32'h3FF70009);
    for (int i = 0; i < K*K; i++) weight1[16*i +: 16] = 16'(i);
`endif

    step(0, 1, 0); step(0, 1, 0);
    mode = 1; mN = 5; mS = 2;
    clr();
    for (int i = 0; i < 25; i++) step(1, 1, i);
    flush();
    chk_frame("stride", 312, 384, 672, 744);
    chk_edges("stride", 13, 15, 23, 25);

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
